// File: rtl/irq_prio_pkg.sv
// Shared widths and FSM state type for the 4-line interrupt priority controller.
package irq_prio_pkg;
  localparam int unsigned REQ_W = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;
endpackage

// File: rtl/irq_prio_ctrl_if.sv
// Request/grant bundle between interrupt sources, the controller and its consumer.
interface irq_prio_ctrl_if
  import irq_prio_pkg::*;
();
  logic [REQ_W-1:0] req;
  logic [REQ_W-1:0] mask;
  logic             ack;
  logic [ID_W-1:0]  irq_id;
  logic             irq_valid;
  logic [REQ_W-1:0] pending;

  modport master (
    output req, mask, ack,
    input  irq_id, irq_valid, pending
  );

  modport slave (
    input  req, mask, ack,
    output irq_id, irq_valid, pending
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational 4:2 priority encoder; the highest set index wins.
module irq_prio_enc
  import irq_prio_pkg::*;
(
  input  logic [REQ_W-1:0] vec,
  output logic [ID_W-1:0]  id,
  output logic             any_set
);

  // Highest-index-first selection
  always_comb begin
    id      = 2'd0;
    any_set = 1'b0;
    if (vec[3]) begin
      id      = 2'd3;
      any_set = 1'b1;
    end else if (vec[2]) begin
      id      = 2'd2;
      any_set = 1'b1;
    end else if (vec[1]) begin
      id      = 2'd1;
      any_set = 1'b1;
    end else if (vec[0]) begin
      id      = 2'd0;
      any_set = 1'b1;
    end else begin
      id      = 2'd0;
      any_set = 1'b0;
    end
  end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Sticky-pending interrupt priority controller with frozen grant until ack.
// Define IRQ_EDGE_DETECT_EN for rising-edge request detection; default is level mode.
module irq_prio_ctrl
  import irq_prio_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  irq_prio_ctrl_if.slave  bus
);

  logic [REQ_W-1:0] det_s;
  logic [REQ_W-1:0] elig_s;
  logic [REQ_W-1:0] clr_s;
  logic [REQ_W-1:0] pend_nxt_s;
  logic [ID_W-1:0]  enc_id_s;
  logic             any_s;

  logic [REQ_W-1:0] pend_r;
  logic [ID_W-1:0]  irq_id_r;
  logic             irq_valid_r;
  state_t           state_r;

`ifdef IRQ_EDGE_DETECT_EN
  logic [REQ_W-1:0] hist_r;

  // Previous-cycle request sample for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r <= 4'b0000;
    end else begin
      hist_r <= bus.req;
    end
  end

  assign det_s = bus.req & ~hist_r;
`else
  assign det_s = bus.req;
`endif

  // Arbitration works on registered pending, which gives the two-edge latency
  assign elig_s = pend_r & bus.mask;

  irq_prio_enc u_enc (
    .vec     (elig_s),
    .id      (enc_id_s),
    .any_set (any_s)
  );

  // Clear mask for the acknowledged line
  always_comb begin
    clr_s = 4'b0000;
    if ((state_r == PRESENT) && bus.ack) begin
      clr_s[irq_id_r] = 1'b1;
    end else begin
      clr_s = 4'b0000;
    end
  end

  // A new detection on the line being cleared keeps it pending
  assign pend_nxt_s = (pend_r & ~clr_s) | det_s;

  // Grant FSM with pending capture and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      pend_r      <= 4'b0000;
      irq_id_r    <= 2'd0;
      irq_valid_r <= 1'b0;
    end else begin
      pend_r <= pend_nxt_s;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            state_r     <= PRESENT;
            irq_id_r    <= enc_id_s;
            irq_valid_r <= 1'b1;
          end else begin
            state_r     <= IDLE;
            irq_id_r    <= 2'd0;
            irq_valid_r <= 1'b0;
          end
        end
        PRESENT: begin
          if (bus.ack) begin
            state_r     <= IDLE;
            irq_id_r    <= 2'd0;
            irq_valid_r <= 1'b0;
          end else begin
            state_r     <= PRESENT;
            irq_id_r    <= irq_id_r;
            irq_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          irq_id_r    <= 2'd0;
          irq_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_id    = irq_id_r;
  assign bus.irq_valid = irq_valid_r;
  assign bus.pending   = pend_r;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Scoreboard bench for irq_prio_ctrl: directed scenarios plus random traffic vs a reference model.
module tb_irq_prio_ctrl;
  import irq_prio_pkg::*;

`ifdef IRQ_EDGE_DETECT_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  irq_prio_ctrl_if bus ();

  irq_prio_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [1:0] id;
    logic [3:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: pending bits, presented line (-1 = none), last request sample
  logic [3:0] m_pend = 4'b0000;
  logic [3:0] m_prev = 4'b0000;
  int         m_cur = -1;
  int         m_grants = 0;
  int         dut_grants = 0;
  logic       prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One rising edge of the specified behaviour
  task automatic model_edge(input logic r, input logic [3:0] rq, input logic [3:0] mk, input logic ak);
    logic [3:0] det;
    logic [3:0] clr;
    int sel;
    if (r) begin
      m_pend = 4'b0000;
      m_prev = 4'b0000;
      m_cur  = -1;
    end else begin
      for (int i = 0; i < 4; i++)
        det[i] = rq[i] && (EDGE_MODE ? !m_prev[i] : 1'b1);
      clr = 4'b0000;
      if (m_cur < 0) begin
        sel = -1;
        for (int i = 3; i >= 0; i--)
          if (sel < 0 && m_pend[i] && mk[i]) sel = i;
        if (sel >= 0) begin
          m_cur = sel;
          m_grants++;
        end
      end else if (ak) begin
        clr[m_cur] = 1'b1;
        m_cur = -1;
      end
      m_pend = (m_pend & ~clr) | det;
      m_prev = rq;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] mk, input logic ak);
    exp_t e;
    @(negedge clk);
    rst      = r;
    bus.req  = rq;
    bus.mask = mk;
    bus.ack  = ak;
    model_edge(r, rq, mk, ak);
    e.valid = (m_cur >= 0);
    e.id    = (m_cur >= 0) ? m_cur[1:0] : 2'd0;
    e.pend  = m_pend;
    exp_q.push_back(e);
    if (r) begin
      #1;
      check("rst_async_valid", {31'd0, bus.irq_valid}, 32'd0);
      check("rst_async_id", {30'd0, bus.irq_id}, 32'd0);
      check("rst_async_pending", {28'd0, bus.pending}, 32'd0);
    end
  endtask

  task automatic idle(input int n, input logic [3:0] mk);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000, mk, 1'b0);
  endtask

  // Monitor: compare every registered output update against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.irq_valid && !prev_valid) dut_grants++;
      prev_valid = bus.irq_valid;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("irq_valid", {31'd0, bus.irq_valid}, {31'd0, e.valid});
        check("irq_id", {30'd0, bus.irq_id}, {30'd0, e.id});
        check("pending", {28'd0, bus.pending}, {28'd0, e.pend});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rq;
    logic [3:0] mk;
    bus.req  = 4'b0000;
    bus.mask = 4'b1111;
    bus.ack  = 1'b0;

    step(1'b1, 4'b0000, 4'b1111, 1'b0);
    idle(2, 4'b1111);

    // Priority: lines 2 and 0 together, serviced high first
    step(1'b0, 4'b0101, 4'b1111, 1'b0);
    idle(2, 4'b1111);
    step(1'b0, 4'b0000, 4'b1111, 1'b1);
    idle(2, 4'b1111);
    step(1'b0, 4'b0000, 4'b1111, 1'b1);
    idle(2, 4'b1111);

    // Freeze: line 1 presented, line 3 arrives later
    step(1'b0, 4'b0010, 4'b1111, 1'b0);
    idle(2, 4'b1111);
    step(1'b0, 4'b1000, 4'b1111, 1'b0);
    idle(3, 4'b1111);
    step(1'b0, 4'b0000, 4'b1111, 1'b1);
    idle(2, 4'b1111);
    step(1'b0, 4'b0000, 4'b1111, 1'b1);
    idle(2, 4'b1111);

    // Masking: line 3 held pending while disabled, then enabled
    step(1'b0, 4'b1000, 4'b0111, 1'b0);
    idle(3, 4'b0111);
    idle(2, 4'b1111);
    step(1'b0, 4'b0000, 4'b1111, 1'b1);
    idle(2, 4'b1111);

    // Collision: line 2 re-detected on its own ack edge
    step(1'b0, 4'b0100, 4'b1111, 1'b0);
    idle(2, 4'b1111);
    step(1'b0, 4'b0100, 4'b1111, 1'b1);
    idle(3, 4'b1111);
    step(1'b0, 4'b0000, 4'b1111, 1'b1);
    idle(2, 4'b1111);

    // Reset while presenting with pending 1010
    step(1'b0, 4'b1010, 4'b1111, 1'b0);
    idle(2, 4'b1111);
    step(1'b1, 4'b0000, 4'b1111, 1'b0);
    step(1'b1, 4'b0000, 4'b1111, 1'b0);
    idle(3, 4'b1111);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      rq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      mk = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
      step(($urandom_range(0, 99) == 0), rq, mk, 1'($urandom_range(0, 1)));
    end

    // Held line with continuous ack: one grant (edge) or one every two cycles (level)
    step(1'b1, 4'b0000, 4'b0010, 1'b0);
    idle(1, 4'b0010);
    m_grants   = 0;
    dut_grants = 0;
    for (int n = 0; n < 10; n++) step(1'b0, 4'b0010, 4'b0010, 1'b1);
    step(1'b0, 4'b0000, 4'b0010, 1'b1);
    idle(2, 4'b0010);
    @(posedge clk);
    #2;
    check("held_grants_model", dut_grants, m_grants);
    check("held_grants_expected", dut_grants, EDGE_MODE ? 32'd1 : 32'd5);

    idle(2, 4'b1111);
    @(posedge clk);
    #2;
    check("queue_drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_prio_ctrl.md
IRQ_PRIO_CTRL -- requirements
Module: irq_prio_ctrl

Interface
REQ-001 Parameters: none; request width is fixed at 4.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  request lines; req[3] is highest priority and req[0] lowest.
REQ-006 mask  input  4  per-line enable; a line is eligible only when its mask bit is 1.
REQ-007 ack  input  1  consumer acknowledge of the presented request.
REQ-008 irq_id  output  2  registered index of the presented line, 3..0.
REQ-009 irq_valid  output  1  registered; high while a request is presented.
REQ-010 pending  output  4  registered sticky pending bits, raw and unmasked.

Function
REQ-011 A line is captured into pending[i] at every rising edge where it is detected (see REQ-022/023); pending bits SHALL be sticky until cleared.
REQ-012 FSM states SHALL be IDLE and PRESENT.
REQ-013 IDLE: if (pending & mask) != 0 at an edge, go to PRESENT, load irq_id with the highest set index of (pending & mask) and set irq_valid=1.
REQ-014 Registered pending is used by REQ-013: a request first sampled at edge k gives irq_valid=1 after edge k+1 (2-edge latency).
REQ-015 PRESENT: irq_id SHALL stay frozen; later higher-priority requests and mask changes SHALL NOT alter it.
REQ-016 PRESENT with ack=1 at an edge: clear pending[irq_id], set irq_valid=0 and go to IDLE; the next grant comes no earlier than one edge later (one-cycle bubble).
REQ-017 ack in IDLE SHALL be ignored.
REQ-018 Simultaneous new detection on line irq_id and ack clear at the same edge: set wins, so pending[irq_id] stays 1.
REQ-019 Unmasked pending bits SHALL still be held and reported on pending.
REQ-020 irq_id=0 with irq_valid=0 SHALL be the idle encoding.

Reset
REQ-021 While rst=1: state=IDLE, pending=4'b0000, irq_id=2'b00, irq_valid=0, edge-history register=4'b0000; reset mid-PRESENT drops the request without an ack.

Configuration
REQ-022 Macro IRQ_EDGE_DETECT_EN defined: line i is detected when req[i]=1 and the previous sampled req[i]=0 (rising edge); a held-high line sets pending once only.
REQ-023 IRQ_EDGE_DETECT_EN undefined: level mode; line i is detected at every edge where req[i]=1, so a held line re-pends immediately after ack; no history register is built.

Structure
REQ-024 Package irq_prio_pkg SHALL hold the FSM state typedef (IDLE, PRESENT), the request width constant (4) and the id width constant (2).
REQ-025 Sub-module irq_prio_enc SHALL be a combinational 4:2 highest-index priority encoder with an any-set flag, instantiated on (pending & mask).
REQ-026 Target implementation size is 120-400 RTL lines including the sub-module.

Verification
REQ-027 Reset: assert rst mid-PRESENT with pending=4'b1010 -> same cycle irq_valid=0, pending=0, irq_id=0; after release, outputs stay 0 with req=0.
REQ-028 Priority: mask=4'hF, req=4'b0101 pulsed at edge k -> irq_valid=1, irq_id=2 after edge k+1; ack -> irq_id=0 presented two edges later; second ack -> pending=0.
REQ-029 Freeze: irq_id=1 presented, then req[3] pulsed -> irq_id stays 1 until ack; then irq_id=3.
REQ-030 Masking: mask=4'b0111, req[3] pulsed -> pending=4'b1000, irq_valid stays 0; set mask[3]=1 -> irq_valid=1, irq_id=3 one edge later.
REQ-031 Collision: req[2] pulsed again at the ack edge for irq_id=2 -> pending[2] remains 1 and line 2 is re-presented.
REQ-032 Mode: req[1] held high for 10 cycles with acks -> with IRQ_EDGE_DETECT_EN, exactly one grant; without it, a grant every 2-3 cycles.
